// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction fetch bridge: word constants, enable/stall
// encodings and the fetch FSM state type.
package inst_fetch_bridge_pkg;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [31:0] NopInst     = 32'h0000_0000;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic        Stop        = 1'b1;
    localparam logic        NoStop      = 1'b0;

    typedef enum logic {
        IfbIdle = 1'b0,
        IfbBusy = 1'b1
    } ifb_state_e;

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// PC-stage / IF-ID / instruction-memory signals of the fetch bridge.
// slave is the bridge's view; master is the surrounding pipeline and memory.
interface inst_fetch_bridge_if;

    logic        ce_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic        inst_err_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    modport slave (
        input  ce_i, pc_i, flush_i, mem_ack_i, mem_data_i,
        output inst_o, inst_err_o, stallreq_o, mem_req_o, mem_addr_o
    );

    modport master (
        output ce_i, pc_i, flush_i, mem_ack_i, mem_data_i,
        input  inst_o, inst_err_o, stallreq_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/fetch_timeout_cnt.sv
// 8-bit fetch timeout counter; expired_o flags the last allowed wait cycle (TIMEOUT-1).
module fetch_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= 8'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired_o = (cnt_q == LastCount);

endmodule

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns PC-stage fetches into req/ack memory transactions,
// keeps one tagged instruction word and stalls the pipeline while a fetch is outstanding.
module inst_fetch_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_bridge_if.slave bus
);

    import inst_fetch_bridge_pkg::*;

    ifb_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        discard_q, discard_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_tag_q, buf_tag_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        buf_err_q, buf_err_d;

    logic        aligned;
    logic        hit;
    logic        fill;
    logic [31:0] fill_data;
    logic        fill_err;
    logic        cnt_clr;
    logic        cnt_en;
    logic        expired;

    assign aligned = (bus.pc_i[1:0] == 2'b00);
    assign hit     = bus.ce_i & buf_valid_q & (buf_tag_q == bus.pc_i);

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (expired)
    );

    // Output mux depends only on registered state and pc_i/ce_i, never on mem_ack_i.
    always_comb begin
        bus.inst_o     = ZeroWord;
        bus.inst_err_o = 1'b0;
        bus.stallreq_o = NoStop;
        if (bus.ce_i == ChipEnable) begin
            if (!aligned) begin
                bus.inst_err_o = 1'b1;
            end else if (hit) begin
                bus.inst_o     = buf_data_q;
                bus.inst_err_o = buf_err_q;
            end else begin
                bus.stallreq_o = Stop;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        discard_d   = discard_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        buf_err_d   = buf_err_q;
        fill        = 1'b0;
        fill_data   = ZeroWord;
        fill_err    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IfbIdle: begin
                if ((bus.ce_i == ChipEnable) && aligned && !hit) begin
                    state_d   = IfbBusy;
                    req_d     = 1'b1;
                    addr_d    = bus.pc_i;
                    discard_d = bus.flush_i;
                    cnt_clr   = 1'b1;
                end
            end
            IfbBusy: begin
                cnt_en = 1'b1;
                if (bus.flush_i) begin
                    discard_d = 1'b1;
                end
                if (bus.mem_ack_i) begin
                    state_d   = IfbIdle;
                    req_d     = 1'b0;
                    fill      = !discard_q;
                    fill_data = bus.mem_data_i;
                end else if (expired) begin
                    state_d  = IfbIdle;
                    req_d    = 1'b0;
                    fill     = !discard_q;
                    fill_err = 1'b1;
                end
            end
        endcase

        // A flush wins over a fill landing in the same cycle.
        if (bus.flush_i) begin
            buf_valid_d = 1'b0;
        end else if (fill) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = addr_q;
            buf_data_d  = fill_data;
            buf_err_d   = fill_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IfbIdle;
            req_q       <= 1'b0;
            addr_q      <= ZeroWord;
            discard_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= ZeroWord;
            buf_data_q  <= NopInst;
            buf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            buf_err_q   <= buf_err_d;
        end
    end

    assign bus.mem_req_o  = req_q;
    assign bus.mem_addr_o = addr_q;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed scenarios plus a randomized phase, all checked
// against a fetch-level reference model with a latency-programmable memory responder.
module tb_inst_fetch_bridge;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_bridge_if bus ();

    inst_fetch_bridge #(
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks;
    int          errors;

    // Memory responder: ack comes lat cycles after req rises (lat=0 never acks).
    int          lat;
    bit          stray;
    bit          mem_active;
    int          mem_cnt;

    // Reference model: one buffered word plus the outstanding fetch.
    bit          m_busy;
    int unsigned m_wait;
    bit          m_discard;
    logic [31:0] m_addr;
    bit          b_v;
    logic [31:0] b_tag;
    logic [31:0] b_data;
    bit          b_err;

    logic [31:0] o_inst;
    logic        o_err;
    logic        o_stall;
    logic        o_req;
    logic [31:0] o_addr;
    logic        prev_req;
    int          req_rises;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h3401_1100;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_discard = 0; m_addr = 32'h0;
        b_v = 0; b_tag = 32'h0; b_data = 32'h0; b_err = 0;
    endtask

    task automatic drive(input logic ce, input logic [31:0] pc, input logic fl);
        bus.ce_i = ce; bus.pc_i = pc; bus.flush_i = fl;
    endtask

    task automatic check_cycle();
        logic [31:0] e_inst;
        logic        e_err;
        logic        e_stall;
        e_inst = 32'h0; e_err = 1'b0; e_stall = 1'b0;
        if (bus.ce_i) begin
            if (bus.pc_i % 4 != 0) e_err = 1'b1;
            else if (b_v && b_tag == bus.pc_i) begin
                e_inst = b_data; e_err = b_err;
            end else e_stall = 1'b1;
        end
        o_inst = bus.inst_o; o_err = bus.inst_err_o; o_stall = bus.stallreq_o;
        o_req = bus.mem_req_o; o_addr = bus.mem_addr_o;
        chk("inst", o_inst, e_inst);
        chk("inst_err", 32'(o_err), 32'(e_err));
        chk("stallreq", 32'(o_stall), 32'(e_stall));
        chk("mem_req", 32'(o_req), 32'(m_busy));
        if (m_busy) chk("mem_addr", o_addr, m_addr);
        if (o_req === 1'b1 && prev_req !== 1'b1) req_rises++;
        prev_req = o_req;
    endtask

    task automatic model_next();
        bit          fill;
        bit          ferr;
        logic [31:0] fdata;
        fill = 0; ferr = 0; fdata = 32'h0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_busy) begin
                if (bus.mem_ack_i) begin
                    fill = !m_discard; fdata = bus.mem_data_i; m_busy = 0;
                end else if (m_wait + 1 == TO) begin
                    fill = !m_discard; ferr = 1; m_busy = 0;
                end else m_wait++;
                if (bus.flush_i) m_discard = 1;
            end else if (bus.ce_i && bus.pc_i % 4 == 0 && !(b_v && b_tag == bus.pc_i)) begin
                m_busy = 1; m_wait = 0; m_addr = bus.pc_i; m_discard = bus.flush_i;
            end
            if (bus.flush_i) b_v = 0;
            else if (fill) begin
                b_v = 1; b_tag = m_addr; b_data = fdata; b_err = ferr;
            end
        end
    endtask

    task automatic cyc();
        if (bus.mem_req_o === 1'b1) begin
            if (!mem_active) begin
                mem_active = 1; mem_cnt = 0;
            end else mem_cnt++;
        end else mem_active = 0;
        bus.mem_ack_i  = stray || (mem_active && lat != 0 && mem_cnt == lat);
        bus.mem_data_i = bus.mem_ack_i ? mem_word(bus.mem_addr_o) : $urandom;
        @(negedge clk);
        check_cycle();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_hit(input string tag, output int stalls);
        stalls = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (!o_stall) break;
            stalls++;
        end
        chk({tag, "_done"}, 32'(o_stall), 32'h0);
    endtask

    initial begin
        int          n;
        int          r0;
        logic [31:0] pcs[6];
        logic [31:0] cur_pc;

        checks = 0; errors = 0; lat = 2; stray = 0; mem_active = 0; mem_cnt = 0;
        prev_req = 1'b0; req_rises = 0;
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        pcs[3] = 32'hC; pcs[4] = 32'h10; pcs[5] = 32'h6;
        drive(1'b0, 32'h0, 1'b0);
        bus.mem_ack_i = 1'b0; bus.mem_data_i = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);

        // Reset then fetch, L=2.
        drive(1'b1, 32'h0, 1'b0); lat = 2;
        run_until_hit("t1", n);
        chk("t1_stall_cycles", 32'(n), 32'd4);
        chk("t1_inst", o_inst, 32'h3401_1100);

        // Hit hold at 0x4.
        r0 = req_rises;
        drive(1'b1, 32'h4, 1'b0); lat = 1;
        run_until_hit("t2", n);
        chk("t2_stall_cycles", 32'(n), 32'd3);
        repeat (5) begin
            cyc();
            chk("t2_hold_stall", 32'(o_stall), 32'h0);
        end
        chk("t2_req_pulses", 32'(req_rises - r0), 32'd1);

        // Flush on the 2nd BUSY cycle; the PC redirects to 0x100.
        drive(1'b1, 32'h8, 1'b0); lat = 3;
        cyc();
        cyc();
        drive(1'b1, 32'h100, 1'b1);
        cyc();
        drive(1'b1, 32'h100, 1'b0);
        r0 = req_rises;
        for (int i = 0; i < 20 && req_rises == r0; i++) cyc();
        chk("t3_new_req", 32'(req_rises - r0), 32'd1);
        chk("t3_next_addr", o_addr, 32'h100);
        run_until_hit("t3", n);
        chk("t3_inst", o_inst, mem_word(32'h100));
        drive(1'b1, 32'h8, 1'b0);
        cyc();
        chk("t3_discarded", 32'(o_stall), 32'h1);
        run_until_hit("t3b", n);

        // Timeout with no ack.
        drive(1'b1, 32'h10, 1'b0); lat = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (o_req) n++;
            if (!o_stall) break;
        end
        chk("t4_req_cycles", 32'(n), 32'd4);
        chk("t4_inst", o_inst, 32'h0);
        chk("t4_err", 32'(o_err), 32'h1);

        // Misaligned PC.
        drive(1'b1, 32'h6, 1'b0);
        repeat (3) begin
            cyc();
            chk("t5_err", 32'(o_err), 32'h1);
            chk("t5_stall", 32'(o_stall), 32'h0);
            chk("t5_req", 32'(o_req), 32'h0);
        end

        // Reset mid-fetch followed by a stray ack.
        drive(1'b1, 32'h20, 1'b0); lat = 0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h20, 1'b0); stray = 1;
        cyc();
        stray = 0;
        cyc();
        chk("t6_req", 32'(o_req), 32'h0);
        drive(1'b1, 32'h20, 1'b0); lat = 2;
        cyc();
        chk("t6_buf_invalid", 32'(o_stall), 32'h1);
        run_until_hit("t6", n);

        // Randomized traffic.
        cur_pc = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (!o_stall || $urandom_range(0, 3) == 0) cur_pc = pcs[$urandom_range(0, 5)];
            drive(($urandom_range(0, 7) != 0), cur_pc, ($urandom_range(0, 19) == 0));
            stray = ($urandom_range(0, 15) == 0);
            lat   = $urandom_range(0, 5);
            rst   = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0; stray = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Responder side of the PC → instruction-memory interface: consumes the fetch address and chip enable from the PC stage and returns the instruction word to IF/ID. It replaces the zero-latency ROM with a multi-cycle req/ack memory port, holds one fetched word in a tagged buffer, and raises a stall request to the pipeline controller while a fetch is outstanding. It also aborts a fetch on timeout and discards in-flight data on pipeline flush.

## Interface
- `TIMEOUT`, default 255: cycles without `mem_ack_i` before a fetch is aborted; range 1..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ce_i`  in  1  fetch enable from PC stage; 1 = fetch `pc_i`.
- `pc_i`  in  32  fetch byte address.
- `flush_i`  in  1  pipeline flush (exception/interrupt).
- `inst_o`  out  32  instruction to IF/ID.
- `inst_err_o`  out  1  fetch fault for the current `pc_i`: misaligned or timed out.
- `stallreq_o`  out  1  to stall controller; 1 = hold PC and IF.
- `mem_req_o`  out  1  memory request, registered.
- `mem_addr_o`  out  32  word-aligned request address, registered.
- `mem_ack_i`  in  1  single-cycle completion strobe.
- `mem_data_i`  in  32  read data, valid with `mem_ack_i`.

## Operation
- Buffer contents: `buf_valid`, `buf_tag[31:0]`, `buf_data[31:0]`, `buf_err`.
- Hit condition: `ce_i & buf_valid & (buf_tag == pc_i)`.
- Combinational outputs:
  - `ce_i=0`: `inst_o=0`, `inst_err_o=0`, `stallreq_o=0`.
  - `ce_i=1`, `pc_i[1:0]!=0`: `inst_o=0`, `inst_err_o=1`, `stallreq_o=0`. No request is issued.
  - Hit: `inst_o=buf_data`, `inst_err_o=buf_err`, `stallreq_o=0`.
  - Otherwise (aligned miss, or state BUSY): `inst_o=0`, `inst_err_o=0`, `stallreq_o=1`.
- FSM has two states: IDLE and BUSY.
  - IDLE → BUSY on an aligned miss with `ce_i=1`. Next cycle, `mem_req_o=1` and `mem_addr_o=pc_i`; timeout counter cleared; `discard=flush_i`.
  - BUSY:
    - `mem_req_o` and `mem_addr_o` stay stable until ack or timeout.
    - Counter increments each cycle.
    - `flush_i=1` sets `discard`.
  - BUSY → IDLE on `mem_ack_i`:
    - `mem_req_o` drops next cycle.
    - If `!discard`: fill `buf_tag=mem_addr_o`, `buf_data=mem_data_i`, `buf_err=0`, `buf_valid=1`.
  - BUSY → IDLE when the counter reaches `TIMEOUT-1` without ack:
    - `mem_req_o` drops.
    - If `!discard`: fill `buf_tag=mem_addr_o`, `buf_data=0`, `buf_err=1`.
- `flush_i`, any state: clears `buf_valid` the next cycle. A fill in the same cycle as flush is suppressed.
- `ce_i` falling while BUSY: the bus transaction still completes. Fill is allowed unless `discard` is set.
- `mem_ack_i` outside BUSY is ignored.
- Reset: state IDLE, `mem_req_o=0`, `mem_addr_o=0`, `buf_valid=0`, `buf_data=0`, `buf_err=0`, `discard=0`, counter 0. Reset mid-fetch abandons the transaction; a later stray ack is ignored.

## Timing
- Hit: 0-cycle latency; `inst_o` is valid in the same cycle as `pc_i`.
- Miss with memory latency L (ack L cycles after req rises, L≥1):
  - `stallreq_o` high for L+2 cycles (issue cycle, L wait cycles, fill cycle).
  - Hit on the cycle after the fill.
- The minimum gap between requests is one cycle of `mem_req_o=0`; the bus requires this.
- Sequential fetch with L=1 gives one instruction per 4 cycles. No prefetch is in scope.
- `stallreq_o` is combinational from registered state plus `pc_i`/`ce_i`. It must not depend on `mem_ack_i` combinationally.

## Structure
- Shared defines header:
  - `ZeroWord` and the NOP encoding (`32'h0`).
  - `ChipEnable`/`ChipDisable`, `Stop`/`NoStop`.
  - FSM state encoding `IfbIdle`/`IfbBusy`.
- One sub-module, `fetch_timeout_cnt`: 8-bit counter with clear/enable and an `expired` output at `TIMEOUT-1`.
- The top level holds the FSM, the buffer and the output mux.
- The stall controller ORs `stallreq_o` into `stall[0]` and `stall[1]`.

## Test plan
- **Reset then fetch:** `rst=1` for 2 cycles, then `ce_i=1`, `pc_i=0`, memory L=2 returning `32'h34011100`. Required: `stallreq_o=1` for 4 cycles, `mem_addr_o=0`, then `inst_o=32'h34011100` with `stallreq_o=0`.
- **Hit hold:** with PC stalled at `0x4` after a fill, hold 5 cycles. Required: `stallreq_o=0` and only one `mem_req_o` pulse.
- **Flush mid-fetch:** `pc_i=0x8`, L=3, `flush_i` on the 2nd BUSY cycle, `pc_i` becomes `0x100`. Required: ack data not written; the next request has `mem_addr_o=0x100`.
- **Timeout:** `TIMEOUT=4`, no ack. Required: `mem_req_o` drops after 4 cycles; at `pc_i=0x10`, `inst_o=0` and `inst_err_o=1`.
- **Misaligned:** `pc_i=0x6`, `ce_i=1`. Required: `inst_err_o=1`, `stallreq_o=0`, `mem_req_o` stays 0.
- **Reset mid-fetch:** `rst` during BUSY, then ack arrives. Required: ack ignored, `buf_valid=0`, `mem_req_o=0`.
